sprite_layer: RTL and testbench
===============================

# sprite_layer

Parametrised single-sprite render stage for the VGA pixel path. Takes the current scan coordinates from `vgac`, computes a row-major address into an external asynchronous sprite ROM of `SPR_W`×`SPR_H` pixels, and composites the sprite over a background pixel using a transparency key. The sprite position can be updated at any time but takes effect only at a frame boundary, so a frame never shows two positions. Output feeds `vgac.d_in` directly or the next `sprite_layer` in a chain.

## Interface
- `SPR_W`, 100, sprite width in pixels
- `SPR_H`, 100, sprite height in pixels
- `ADDR_W`, 14, ROM address width; `SPR_W*SPR_H <= 2**ADDR_W` required
- `COLOR_W`, 12, pixel width (4:4:4 RGB)
- `X_W`, 10, column coordinate width
- `Y_W`, 9, row coordinate width
- `KEY_COLOR`, 12'hF0F, transparent ROM value
- `clk  in  1  system clock; single clock domain`
- `rstn  in  1  reset, synchronous, active-low`
- `pix_en  in  1  pixel strobe; the pipeline advances only when high`
- `col_addr  in  X_W  current scan column`
- `row_addr  in  Y_W  current scan row`
- `frame_start  in  1  one-cycle pulse at the start of each frame`
- `pos_x  in  X_W  requested sprite left edge`
- `pos_y  in  Y_W  requested sprite top edge`
- `pos_wr  in  1  one-cycle request to load pos_x/pos_y`
- `pos_ack  out  1  one-cycle pulse when a pending position is applied`
- `rom_addr  out  ADDR_W  registered ROM address`
- `rom_data  in  COLOR_W  ROM output, combinational from rom_addr`
- `bg_in  in  COLOR_W  background pixel, aligned with col_addr/row_addr`
- `pix_out  out  COLOR_W  composited pixel`
- `pix_hit  out  1  high when pix_out is an opaque sprite pixel`

## Operation
- Registers: active position (`act_x`, `act_y`), shadow position (`shd_x`, `shd_y`), `pending` flag.
- `pos_wr`: captures `pos_x`/`pos_y` into the shadow registers and sets `pending`. A second write before application overwrites the shadow.
- `frame_start` with `pending`=1: shadow is copied to active, `pending` clears, `pos_ack`=1 for one cycle. With `pending`=0, nothing changes and `pos_ack` stays 0.
- Simultaneous `frame_start` and `pos_wr`: the old shadow is applied this frame. The new value lands in the shadow, `pending` stays 1, and it is applied at the next `frame_start`.
- Stage 0 (on `pix_en`):
  - `inside` = (`col_addr >= act_x`) && (`col_addr < act_x+SPR_W`) && (`row_addr >= act_y`) && (`row_addr < act_y+SPR_H`).
  - Sums are computed at X_W+1 / Y_W+1 bits, so a sprite partly off the right or bottom edge clips with no wrap.
  - `rom_addr` ← `inside ? (row_addr-act_y)*SPR_W + (col_addr-act_x) : 0`.
  - `inside` and `bg_in` are delayed to stage 1.
- Stage 1 (on `pix_en`):
  - `opaque` = `inside_d && rom_data != KEY_COLOR`.
  - `pix_out` ← `opaque ? rom_data : bg_d`.
  - `pix_hit` ← `opaque`.
- `pix_en`=0: all pipeline registers hold their values. The position logic still runs on every `clk`.
- Reset (`rstn`=0 at a `clk` edge): all outputs 0; active position 0; shadow 0; `pending` 0; delayed stage registers 0. Reset mid-frame discards any pending write.

## Timing
- Latency: 2 `pix_en` strobes from coordinates/`bg_in` to `pix_out`/`pix_hit`.
- `rom_addr` is valid 1 strobe after the coordinates. `rom_data` is sampled on the next strobe, so the ROM must settle within one `clk` period.
- `pos_ack` is asserted on the cycle after the `frame_start` edge (registered) and lasts exactly one `clk`.
- A position change affects the first pixel whose coordinates enter stage 0 after that edge.
- Throughput: one pixel per strobe, no stalls.

## Configuration
- `SPRITE_MIRROR_EN` defined:
  - Adds input `mirror_x` (1 bit), captured into the shadow with `pos_wr` and applied together with the position.
  - When active mirror = 1, the column term becomes `SPR_W-1-(col_addr-act_x)`.
- Undefined: port absent; addressing is always non-mirrored.

## Test plan
- Reset with `pix_en`=1 held -> `pix_out`=0, `pix_hit`=0, `rom_addr`=0, `pos_ack`=0 throughout reset and on the first cycle after.
- Defaults, act=(0,0), scan (col 5, row 2) -> `rom_addr`=205 after 1 strobe; with ROM returning 12'h0AE, `pix_out`=12'h0AE and `pix_hit`=1 after 2 strobes; scan (100,0) -> `rom_addr`=0, `pix_out`=`bg_in`.
- ROM returns 12'hF0F inside the sprite, `bg_in`=12'h123 -> `pix_out`=12'h123, `pix_hit`=0.
- `pos_wr` (300,200) mid-frame -> no change until `frame_start`, then `pos_ack` pulses once; (300,200) maps to `rom_addr` 0 and (299,200) is outside.
- `pos_wr` (600,400) with `X_W`=10, `Y_W`=9 -> col 639/row 479 gives `rom_addr`=79*100+39=7939; cols 0..59 and rows 0..19 stay outside (no wrap).
- `pos_wr` coincident with `frame_start` while (10,10) is pending -> (10,10) applied now, new value applied at the following `frame_start`, two `pos_ack` pulses total.

Source files
------------

// File: rtl/sprite_layer.sv
// sprite_layer: single-sprite render stage for the VGA pixel path.
// Builds a row-major address into an external asynchronous sprite ROM from the
// scan coordinates, then composites the ROM pixel over the background using a
// transparency key. Position updates are staged in a shadow register and only
// take effect at frame_start, so a frame never shows two positions.
// Optional feature: define SPRITE_MIRROR_EN to add a horizontal-mirror input.
module sprite_layer #(
  parameter int                 SPR_W     = 100,
  parameter int                 SPR_H     = 100,
  parameter int                 ADDR_W    = 14,
  parameter int                 COLOR_W   = 12,
  parameter int                 X_W       = 10,
  parameter int                 Y_W       = 9,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pix_en,
  input  logic [X_W-1:0]     col_addr,
  input  logic [Y_W-1:0]     row_addr,
  input  logic               frame_start,
  input  logic [X_W-1:0]     pos_x,
  input  logic [Y_W-1:0]     pos_y,
  input  logic               pos_wr,
`ifdef SPRITE_MIRROR_EN
  input  logic               mirror_x,
`endif
  output logic               pos_ack,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  input  logic [COLOR_W-1:0] bg_in,
  output logic [COLOR_W-1:0] pix_out,
  output logic               pix_hit
);

  // Sprite extents widened by one bit so right/bottom clipping never wraps.
  localparam logic [X_W:0]      SPR_W_X    = (X_W+1)'(SPR_W);
  localparam logic [Y_W:0]      SPR_H_Y    = (Y_W+1)'(SPR_H);
  localparam logic [ADDR_W-1:0] SPR_W_A    = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] SPR_W_M1_A = ADDR_W'(SPR_W - 1);

  // Position registers
  logic [X_W-1:0] act_x_q, act_x_d, shd_x_q, shd_x_d;
  logic [Y_W-1:0] act_y_q, act_y_d, shd_y_q, shd_y_d;
  logic           pending_q, pending_d;
  logic           pos_ack_q, pos_ack_d;
`ifdef SPRITE_MIRROR_EN
  logic           act_mir_q, act_mir_d, shd_mir_q, shd_mir_d;
`endif

  // Pixel pipeline registers
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               inside_d_q, inside_d_d;
  logic [COLOR_W-1:0] bg_d_q, bg_d_d;
  logic [COLOR_W-1:0] pix_out_q, pix_out_d;
  logic               pix_hit_q, pix_hit_d;

  // Stage-0 / stage-1 combinational terms
  logic               inside_s;
  logic [X_W-1:0]     col_off_s;
  logic [Y_W-1:0]     row_off_s;
  logic [ADDR_W-1:0]  col_term_s;
  logic [ADDR_W-1:0]  lin_addr_s;
  logic               opaque_s;

  // Shadow capture on pos_wr; shadow-to-active transfer at frame_start. A write
  // coinciding with frame_start lands in the shadow after the old shadow is applied.
  always_comb begin
    act_x_d   = act_x_q;
    act_y_d   = act_y_q;
    shd_x_d   = shd_x_q;
    shd_y_d   = shd_y_q;
    pending_d = pending_q;
    pos_ack_d = 1'b0;
`ifdef SPRITE_MIRROR_EN
    act_mir_d = act_mir_q;
    shd_mir_d = shd_mir_q;
`endif
    if (frame_start && pending_q) begin
      act_x_d   = shd_x_q;
      act_y_d   = shd_y_q;
`ifdef SPRITE_MIRROR_EN
      act_mir_d = shd_mir_q;
`endif
      pending_d = 1'b0;
      pos_ack_d = 1'b1;
    end else begin
      pos_ack_d = 1'b0;
    end
    if (pos_wr) begin
      shd_x_d   = pos_x;
      shd_y_d   = pos_y;
`ifdef SPRITE_MIRROR_EN
      shd_mir_d = mirror_x;
`endif
      pending_d = 1'b1;
    end else begin
      shd_x_d   = shd_x_d;
      shd_y_d   = shd_y_d;
    end
  end

  // Stage-0 hit test and row-major ROM address relative to the active position.
  always_comb begin
    inside_s  = ({1'b0, col_addr} >= {1'b0, act_x_q}) &&
                ({1'b0, col_addr} <  ({1'b0, act_x_q} + SPR_W_X)) &&
                ({1'b0, row_addr} >= {1'b0, act_y_q}) &&
                ({1'b0, row_addr} <  ({1'b0, act_y_q} + SPR_H_Y));
    col_off_s  = col_addr - act_x_q;
    row_off_s  = row_addr - act_y_q;
    col_term_s = ADDR_W'(col_off_s);
`ifdef SPRITE_MIRROR_EN
    if (act_mir_q) begin
      col_term_s = SPR_W_M1_A - ADDR_W'(col_off_s);
    end else begin
      col_term_s = ADDR_W'(col_off_s);
    end
`endif
    lin_addr_s = ADDR_W'(row_off_s) * SPR_W_A + col_term_s;
  end

  // Pipeline next-state: advance on pix_en, otherwise hold every stage.
  always_comb begin
    opaque_s   = inside_d_q && (rom_data != KEY_COLOR);
    rom_addr_d = rom_addr_q;
    inside_d_d = inside_d_q;
    bg_d_d     = bg_d_q;
    pix_out_d  = pix_out_q;
    pix_hit_d  = pix_hit_q;
    if (pix_en) begin
      rom_addr_d = inside_s ? lin_addr_s : {ADDR_W{1'b0}};
      inside_d_d = inside_s;
      bg_d_d     = bg_in;
      pix_out_d  = opaque_s ? rom_data : bg_d_q;
      pix_hit_d  = opaque_s;
    end else begin
      rom_addr_d = rom_addr_q;
      inside_d_d = inside_d_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      act_x_q    <= {X_W{1'b0}};
      act_y_q    <= {Y_W{1'b0}};
      shd_x_q    <= {X_W{1'b0}};
      shd_y_q    <= {Y_W{1'b0}};
      pending_q  <= 1'b0;
      pos_ack_q  <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      act_mir_q  <= 1'b0;
      shd_mir_q  <= 1'b0;
`endif
      rom_addr_q <= {ADDR_W{1'b0}};
      inside_d_q <= 1'b0;
      bg_d_q     <= {COLOR_W{1'b0}};
      pix_out_q  <= {COLOR_W{1'b0}};
      pix_hit_q  <= 1'b0;
    end else begin
      act_x_q    <= act_x_d;
      act_y_q    <= act_y_d;
      shd_x_q    <= shd_x_d;
      shd_y_q    <= shd_y_d;
      pending_q  <= pending_d;
      pos_ack_q  <= pos_ack_d;
`ifdef SPRITE_MIRROR_EN
      act_mir_q  <= act_mir_d;
      shd_mir_q  <= shd_mir_d;
`endif
      rom_addr_q <= rom_addr_d;
      inside_d_q <= inside_d_d;
      bg_d_q     <= bg_d_d;
      pix_out_q  <= pix_out_d;
      pix_hit_q  <= pix_hit_d;
    end
  end

  assign pos_ack  = pos_ack_q;
  assign rom_addr = rom_addr_q;
  assign pix_out  = pix_out_q;
  assign pix_hit  = pix_hit_q;

endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench for sprite_layer with default parameters. The ROM is modelled
// as a bench-driven value (rom_val) presented combinationally on rom_data.
module tb_sprite_layer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pix_en;
  logic [9:0]  col_addr;
  logic [8:0]  row_addr;
  logic        frame_start;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        pos_wr;
`ifdef SPRITE_MIRROR_EN
  logic        mirror_x;
`endif
  logic        pos_ack;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] bg_in;
  logic [11:0] pix_out;
  logic        pix_hit;
  logic [11:0] rom_val;

  int errors = 0;
  int checks = 0;

  assign rom_data = rom_val;

  always #5 clk = ~clk;

  sprite_layer dut (
    .clk         (clk),
    .rstn        (rstn),
    .pix_en      (pix_en),
    .col_addr    (col_addr),
    .row_addr    (row_addr),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_wr      (pos_wr),
`ifdef SPRITE_MIRROR_EN
    .mirror_x    (mirror_x),
`endif
    .pos_ack     (pos_ack),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .bg_in       (bg_in),
    .pix_out     (pix_out),
    .pix_hit     (pix_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [9:0] c, input logic [8:0] r, input logic [11:0] bg);
    col_addr = c;
    row_addr = r;
    bg_in    = bg;
  endtask

  initial begin
    rstn = 1'b0; pix_en = 1'b1; frame_start = 1'b0; pos_wr = 1'b0;
    pos_x = 10'd0; pos_y = 9'd0; rom_val = 12'h000;
`ifdef SPRITE_MIRROR_EN
    mirror_x = 1'b0;
`endif
    scan(10'd0, 9'd0, 12'h000);

    // Reset with pix_en held high
    tick(); tick();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix_out",  32'(pix_out),  32'd0);
    chk("rst_pix_hit",  32'(pix_hit),  32'd0);
    chk("rst_pos_ack",  32'(pos_ack),  32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("post_rst_pix_out",  32'(pix_out),  32'd0);
    chk("post_rst_pix_hit",  32'(pix_hit),  32'd0);
    chk("post_rst_pos_ack",  32'(pos_ack),  32'd0);

    // Default position (0,0): col 5 row 2 -> address 205, opaque pixel
    scan(10'd5, 9'd2, 12'h555); rom_val = 12'h0AE;
    tick();
    chk("addr_5_2", 32'(rom_addr), 32'd205);
    tick();
    chk("pix_5_2", 32'(pix_out), 32'h0AE);
    chk("hit_5_2", 32'(pix_hit), 32'd1);

    // Column 100 is just right of the sprite -> background
    scan(10'd100, 9'd0, 12'h3C3);
    tick();
    chk("addr_100_0", 32'(rom_addr), 32'd0);
    tick();
    chk("pix_100_0", 32'(pix_out), 32'h3C3);
    chk("hit_100_0", 32'(pix_hit), 32'd0);

    // Key colour inside the sprite -> background shows through
    scan(10'd7, 9'd7, 12'h123); rom_val = 12'hF0F;
    tick();
    chk("addr_7_7", 32'(rom_addr), 32'd707);
    tick();
    chk("pix_key", 32'(pix_out), 32'h123);
    chk("hit_key", 32'(pix_hit), 32'd0);

    // pix_en low: pipeline holds
    pix_en = 1'b0; scan(10'd1, 9'd0, 12'hABC); rom_val = 12'h0AE;
    tick(); tick();
    chk("hold_addr", 32'(rom_addr), 32'd707);
    chk("hold_pix",  32'(pix_out),  32'h123);
    chk("hold_hit",  32'(pix_hit),  32'd0);
    pix_en = 1'b1;

    // pos_wr (300,200) mid-frame: no effect until frame_start
    pos_x = 10'd300; pos_y = 9'd200; pos_wr = 1'b1;
    scan(10'd50, 9'd0, 12'h000);
    tick();
    pos_wr = 1'b0;
    chk("wr300_no_ack", 32'(pos_ack), 32'd0);
    tick();
    chk("wr300_old_pos_addr", 32'(rom_addr), 32'd50);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("wr300_ack", 32'(pos_ack), 32'd1);
    tick();
    chk("wr300_ack_drop", 32'(pos_ack), 32'd0);
    scan(10'd300, 9'd200, 12'h111);
    tick();
    chk("addr_300_200", 32'(rom_addr), 32'd0);
    tick();
    chk("hit_300_200", 32'(pix_hit), 32'd1);
    scan(10'd299, 9'd200, 12'h222);
    tick(); tick();
    chk("hit_299_200", 32'(pix_hit), 32'd0);
    chk("pix_299_200", 32'(pix_out), 32'h222);
    scan(10'd301, 9'd201, 12'h000);
    tick();
    chk("addr_301_201", 32'(rom_addr), 32'd101);

    // pos_wr (600,400): partly off the right/bottom edge, clipped without wrap
    pos_x = 10'd600; pos_y = 9'd400; pos_wr = 1'b1;
    tick();
    pos_wr = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("wr600_ack", 32'(pos_ack), 32'd1);
    scan(10'd639, 9'd479, 12'h000);
    tick();
    chk("addr_639_479", 32'(rom_addr), 32'd7939);
    tick();
    chk("hit_639_479", 32'(pix_hit), 32'd1);
    scan(10'd59, 9'd479, 12'h444);
    tick();
    chk("addr_59_479", 32'(rom_addr), 32'd0);
    tick();
    chk("hit_59_479", 32'(pix_hit), 32'd0);
    scan(10'd639, 9'd19, 12'h000);
    tick();
    chk("addr_639_19", 32'(rom_addr), 32'd0);

    // pos_wr coincident with frame_start while (10,10) is pending
    pos_x = 10'd10; pos_y = 9'd10; pos_wr = 1'b1;
    tick();
    pos_x = 10'd20; pos_y = 9'd30; frame_start = 1'b1;
    tick();
    pos_wr = 1'b0; frame_start = 1'b0;
    chk("coinc_ack1", 32'(pos_ack), 32'd1);
    scan(10'd11, 9'd12, 12'h000);
    tick();
    chk("coinc_ack1_drop", 32'(pos_ack), 32'd0);
    chk("coinc_addr_10_10", 32'(rom_addr), 32'd201);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("coinc_ack2", 32'(pos_ack), 32'd1);
    scan(10'd25, 9'd31, 12'h000);
    tick();
    chk("coinc_addr_20_30", 32'(rom_addr), 32'd105);

    // Reset discards a pending write
    pos_x = 10'd5; pos_y = 9'd5; pos_wr = 1'b1;
    tick();
    pos_wr = 1'b0; rstn = 1'b0;
    tick();
    rstn = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("rst_discard_ack", 32'(pos_ack), 32'd0);
    scan(10'd3, 9'd1, 12'h000);
    tick();
    chk("rst_discard_addr", 32'(rom_addr), 32'd103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
